// File: rtl/register_file_scoreboard.sv
// Multi-entry register file with per-register reservation (busy + tag) scoreboard.
// Tag-matched write-back, optional read bypass, global flush and a saturating stale counter.
module register_file_scoreboard #(
  parameter int NUM_REGS       = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_READ_PORTS = 2,
  parameter int TAG_WIDTH      = 4,
  parameter int BYPASS         = 1,
  parameter int ZERO_REG       = 1,
  localparam int AW            = $clog2(NUM_REGS)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_READ_PORTS*AW-1:0]         rd_addr,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_READ_PORTS-1:0]            rd_busy,
  output logic [NUM_READ_PORTS*TAG_WIDTH-1:0]  rd_tag,
  input  logic                                 rsv_valid,
  input  logic [AW-1:0]                        rsv_addr,
  input  logic [TAG_WIDTH-1:0]                 rsv_tag,
  input  logic                                 wb_valid,
  input  logic [AW-1:0]                        wb_addr,
  input  logic [TAG_WIDTH-1:0]                 wb_tag,
  input  logic [DATA_WIDTH-1:0]                wb_data,
  input  logic                                 flush,
  output logic [7:0]                           stale_count
);

  localparam bit HAS_ZERO = (ZERO_REG != 0);
  localparam bit HAS_BYP  = (BYPASS != 0);

  logic [DATA_WIDTH-1:0] data_q [NUM_REGS];
  logic [TAG_WIDTH-1:0]  tag_q  [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q;
  logic [7:0]            stale_q;

  logic wb_zero, rsv_zero, wb_match, wb_stale, rsv_take;

  // Register 0 (when hardwired) swallows write-backs without counting them as stale.
  assign wb_zero  = HAS_ZERO && (wb_addr == '0);
  assign rsv_zero = HAS_ZERO && (rsv_addr == '0);
  assign wb_match = wb_valid && !wb_zero && busy_q[wb_addr] && (wb_tag == tag_q[wb_addr]);
  assign wb_stale = wb_valid && !wb_zero && !wb_match;
  assign rsv_take = rsv_valid && !rsv_zero && !flush;

  // Later assignments take priority: flush over reserve over write-back clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        data_q[r] <= '0;
        tag_q[r]  <= '0;
      end
      busy_q  <= '0;
      stale_q <= '0;
    end else begin
      if (wb_match) begin
        data_q[wb_addr] <= wb_data;
        busy_q[wb_addr] <= 1'b0;
      end
      if (rsv_take) begin
        busy_q[rsv_addr] <= 1'b1;
        tag_q[rsv_addr]  <= rsv_tag;
      end
      if (flush) busy_q <= '0;
      if (wb_stale && (stale_q != 8'hFF)) stale_q <= stale_q + 8'd1;
    end
  end

  assign stale_count = stale_q;

  for (genvar g = 0; g < NUM_READ_PORTS; g++) begin : g_rd
    logic [AW-1:0] ra;
    logic          ra_zero, byp;

    assign ra      = rd_addr[g*AW +: AW];
    assign ra_zero = HAS_ZERO && (ra == '0);
    assign byp     = HAS_BYP && wb_match && (wb_addr == ra);

    assign rd_data[g*DATA_WIDTH +: DATA_WIDTH] = ra_zero ? '0 : (byp ? wb_data : data_q[ra]);
    assign rd_busy[g]                          = !ra_zero && !byp && busy_q[ra];
    assign rd_tag[g*TAG_WIDTH +: TAG_WIDTH]    = ra_zero ? '0 : tag_q[ra];
  end

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Self-checking bench for register_file_scoreboard: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a behavioural model.
module tb_register_file_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [7:0]  rd_tag;
  logic        rsv_valid = 1'b0;
  logic [3:0]  rsv_addr = '0;
  logic [3:0]  rsv_tag = '0;
  logic        wb_valid = 1'b0;
  logic [3:0]  wb_addr = '0;
  logic [3:0]  wb_tag = '0;
  logic [31:0] wb_data = '0;
  logic        flush = 1'b0;
  logic [7:0]  stale_count;

  int tests = 0;
  int fails = 0;

  register_file_scoreboard dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy), .rd_tag(rd_tag),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_tag(rsv_tag),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_tag(wb_tag), .wb_data(wb_data),
    .flush(flush), .stale_count(stale_count)
  );

  always #5 clk = ~clk;

  // Architectural model: plain arrays updated from the rules at each rising edge.
  logic [31:0] m_data [16];
  logic        m_busy [16];
  logic [3:0]  m_tag  [16];
  int          m_stale;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 16; r++) begin
        m_data[r] = '0; m_busy[r] = 1'b0; m_tag[r] = '0;
      end
      m_stale = 0;
    end else begin
      bit hit;
      hit = wb_valid && wb_addr != 0 && m_busy[wb_addr] && wb_tag == m_tag[wb_addr];
      if (wb_valid && wb_addr != 0 && !hit && m_stale < 255) m_stale = m_stale + 1;
      if (hit) begin
        m_data[wb_addr] = wb_data;
        m_busy[wb_addr] = 1'b0;
      end
      if (rsv_valid && !flush && rsv_addr != 0) begin
        m_busy[rsv_addr] = 1'b1;
        m_tag[rsv_addr]  = rsv_tag;
      end
      if (flush) for (int r = 0; r < 16; r++) m_busy[r] = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_all();
    for (int p = 0; p < 2; p++) begin
      logic [3:0]  a;
      logic [31:0] ed;
      logic        eb;
      logic [3:0]  et;
      a = rd_addr[p*4 +: 4];
      if (a == 0) begin
        ed = '0; eb = 1'b0; et = '0;
      end else if (wb_valid && wb_addr == a && m_busy[a] && wb_tag == m_tag[a]) begin
        ed = wb_data; eb = 1'b0; et = m_tag[a];
      end else begin
        ed = m_data[a]; eb = m_busy[a]; et = m_tag[a];
      end
      check($sformatf("model p%0d r%0d data", p, a), rd_data[p*32 +: 32], ed);
      check($sformatf("model p%0d r%0d busy", p, a), {31'b0, rd_busy[p]}, {31'b0, eb});
      check($sformatf("model p%0d r%0d tag", p, a), {28'b0, rd_tag[p*4 +: 4]}, {28'b0, et});
    end
    check("model stale_count", {24'b0, stale_count}, m_stale[31:0]);
  endtask

  // Drive one cycle's inputs after the edge, then check at the falling edge.
  task automatic apply(input bit rv, input int ra, input int rt,
                       input bit wv, input int wa, input int wt, input logic [31:0] wd,
                       input bit fl, input int p0, input int p1);
    @(posedge clk);
    #1;
    rsv_valid = rv; rsv_addr = 4'(ra); rsv_tag = 4'(rt);
    wb_valid = wv;  wb_addr = 4'(wa);  wb_tag = 4'(wt); wb_data = wd;
    flush = fl;
    rd_addr = {4'(p1), 4'(p0)};
    @(negedge clk);
    if (!rst) compare_all();
  endtask

  task automatic idle(input int p0, input int p1);
    apply(0, 0, 0, 0, 0, 0, '0, 0, p0, p1);
  endtask

  initial begin
    #12;
    for (int r = 0; r < 16; r += 2) begin
      rd_addr = {4'(r + 1), 4'(r)};
      #1;
      check("reset data", rd_data[31:0] | rd_data[63:32], 32'h0);
      check("reset busy/tag", {22'b0, rd_busy, rd_tag}, 32'h0);
    end
    check("reset stale", {24'b0, stale_count}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Reserve then matching write-back with bypass.
    apply(1, 3, 5, 0, 0, 0, '0, 0, 3, 3);
    idle(3, 3);
    check("r3 busy pre-wb", {31'b0, rd_busy[0]}, 32'h1);
    apply(0, 0, 0, 1, 3, 5, 32'hDEADBEEF, 0, 3, 3);
    check("r3 bypass data", rd_data[63:32], 32'hDEADBEEF);
    check("r3 bypass busy", {30'b0, rd_busy}, 32'h0);
    idle(3, 3);
    check("r3 stored data p0", rd_data[31:0], 32'hDEADBEEF);
    check("r3 stored data p1", rd_data[63:32], 32'hDEADBEEF);

    // WAW retag: stale write-back dropped.
    apply(1, 4, 1, 0, 0, 0, '0, 0, 4, 4);
    apply(1, 4, 2, 0, 0, 0, '0, 0, 4, 4);
    apply(0, 0, 0, 1, 4, 1, 32'h11, 0, 4, 4);
    idle(4, 4);
    check("r4 data kept", rd_data[31:0], 32'h0);
    check("r4 busy kept", {31'b0, rd_busy[0]}, 32'h1);
    check("r4 tag 2", {28'b0, rd_tag[3:0]}, 32'h2);
    check("stale after WAW", {24'b0, stale_count}, 32'h1);
    apply(0, 0, 0, 1, 4, 2, 32'h22, 0, 4, 4);
    idle(4, 4);
    check("r4 data 22", rd_data[31:0], 32'h22);
    check("r4 busy clear", {31'b0, rd_busy[0]}, 32'h0);

    // Same-cycle reserve and write-back to one register.
    apply(1, 6, 7, 0, 0, 0, '0, 0, 6, 6);
    apply(1, 6, 9, 1, 6, 7, 32'h77, 0, 6, 6);
    idle(6, 6);
    check("r6 data 77", rd_data[31:0], 32'h77);
    check("r6 busy", {31'b0, rd_busy[0]}, 32'h1);
    check("r6 tag 9", {28'b0, rd_tag[3:0]}, 32'h9);

    // Hardwired register 0.
    apply(1, 0, 3, 0, 0, 0, '0, 0, 0, 0);
    apply(0, 0, 0, 1, 0, 3, 32'hFF, 0, 0, 0);
    idle(0, 0);
    check("r0 data", rd_data[31:0], 32'h0);
    check("r0 busy/tag", {27'b0, rd_busy[0], rd_tag[3:0]}, 32'h0);
    check("r0 stale unchanged", {24'b0, stale_count}, 32'h1);

    // Flush drops same-cycle reserve, keeps tags.
    apply(1, 1, 1, 0, 0, 0, '0, 0, 1, 2);
    apply(1, 2, 2, 0, 0, 0, '0, 0, 1, 2);
    apply(1, 5, 3, 0, 0, 0, '0, 0, 1, 5);
    apply(1, 7, 3, 0, 0, 0, '0, 1, 1, 7);
    idle(1, 7);
    check("flush busy r1 r7", {30'b0, rd_busy}, 32'h0);
    check("flush tags r1 r7", {24'b0, rd_tag}, 32'h01);
    idle(2, 5);
    check("flush busy r2 r5", {30'b0, rd_busy}, 32'h0);

    // Saturation of the stale counter.
    for (int i = 0; i < 300; i++) apply(0, 0, 0, 1, 8, 0, 32'(i), 0, 8, 6);
    idle(8, 6);
    check("stale saturated", {24'b0, stale_count}, 32'hFF);

    // Asynchronous reset mid-operation.
    apply(1, 3, 4, 0, 0, 0, '0, 0, 3, 4);
    idle(3, 4);
    check("r3 busy before rst", {31'b0, rd_busy[0]}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("async rst data", rd_data[31:0] | rd_data[63:32], 32'h0);
    check("async rst busy/tag", {22'b0, rd_busy, rd_tag}, 32'h0);
    check("async rst stale", {24'b0, stale_count}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic with frequent collisions.
    for (int i = 0; i < 600; i++) begin
      int ra, wa, wt;
      ra = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 7));
      wa = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 7));
      wt = $urandom_range(0, 1) ? int'(m_tag[wa]) : int'($urandom_range(0, 3));
      apply($urandom_range(0, 1), ra, $urandom_range(0, 3),
            $urandom_range(0, 1), wa, wt, $urandom,
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 7), $urandom_range(0, 1) ? wa : int'($urandom_range(0, 15)));
    end
    idle(1, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/register_file_scoreboard.md
Name: register_file_scoreboard

Overview:
- Parametrised, multi-entry successor to the single register cell: NUM_REGS data registers, each with a write-reservation (busy) bit and a reservation tag.
- Sits between decode/issue (reserve, read) and write-back.
- Tag matching discards stale write-backs after a register is re-reserved (WAW).
- Adds N combinational read ports with optional write-back bypass, a global flush, and a saturating stale-write counter.

Parameters:
- NUM_REGS, 16: number of architectural registers; power of two, >= 2.
- DATA_WIDTH, 32: register data width.
- NUM_READ_PORTS, 2: independent read ports.
- TAG_WIDTH, 4: reservation tag width.
- BYPASS, 1: 1 = read ports forward the same-cycle matching write-back.
- ZERO_REG, 1: 1 = register 0 reads 0, is never busy, and ignores reserve and write-back.
- Local AW = $clog2(NUM_REGS).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_addr  in  NUM_READ_PORTS*AW  read addresses; port i occupies bits [i*AW +: AW].
- rd_data  out  NUM_READ_PORTS*DATA_WIDTH  read data per port.
- rd_busy  out  NUM_READ_PORTS  busy bit per port.
- rd_tag  out  NUM_READ_PORTS*TAG_WIDTH  current reservation tag per port.
- rsv_valid  in  1  reserve request.
- rsv_addr  in  AW  register to reserve.
- rsv_tag  in  TAG_WIDTH  tag of the producing instruction.
- wb_valid  in  1  write-back request.
- wb_addr  in  AW  write-back destination.
- wb_tag  in  TAG_WIDTH  tag of the writing instruction.
- wb_data  in  DATA_WIDTH  write-back data.
- flush  in  1  clear all reservations.
- stale_count  out  8  saturating count of discarded write-backs.

Behaviour:
- Reset (asynchronous, on rst high):
  - All data = 0, all busy = 0, all tags = 0, stale_count = 0.
  - Outputs reflect this immediately: rd_data 0, rd_busy 0, rd_tag 0.
  - Reset asserted mid-operation discards every pending reservation.
- Reads are combinational, zero latency, and return the state as of the last edge (data, busy, tag).
  - BYPASS=1: if wb_valid, wb_addr == rd_addr[i], busy[wb_addr] = 1 and wb_tag == tag[wb_addr], then port i returns rd_data = wb_data, rd_busy = 0, rd_tag = stored tag.
  - BYPASS=0: no forwarding; the new value is visible the cycle after the edge.
- Write-back match: "match" = wb_valid & busy[wb_addr] & (wb_tag == tag[wb_addr]), all evaluated on pre-edge state.
  - Match: data[wb_addr] <= wb_data; busy[wb_addr] <= 0.
  - wb_valid without match (register not busy, or tag differs): data and busy unchanged; stale_count increments, saturating at 255.
- Reserve: rsv_valid sets busy[rsv_addr] <= 1 and tag[rsv_addr] <= rsv_tag, whether or not the register is already busy (retag).
- Simultaneous reserve and write-back to the same register:
  - Match evaluation uses the old tag; the data write follows the match rule.
  - Busy ends at 1 and the tag ends as rsv_tag (reserve wins).
- Simultaneous reserve and write-back to different registers: both take effect independently.
- Flush: all busy <= 0 at the edge; tags hold.
  - A rsv_valid in the same cycle is dropped.
  - A wb_valid in the same cycle still follows the match rule on pre-edge state: data is written on a match, and stale_count increments on a mismatch.
- ZERO_REG=1, register 0:
  - Reads always give data 0, busy 0, tag 0.
  - Reserve to register 0 is a no-op.
  - wb_valid to register 0 is a no-op and does not count as stale.
- Priority at each edge: rst > flush (busy only) > reserve > write-back clear.
- stale_count never wraps; it clears only on rst.

Test Plan:
- Reset then read all registers -> rd_data 0, rd_busy 0, rd_tag 0 on every port; stale_count 0.
- Reserve r3 with tag 5; next cycle write-back r3, tag 5, data 0xDEADBEEF -> read r3 gives busy=1 before the edge; with BYPASS=1 in the wb cycle it gives 0xDEADBEEF, busy=0; after the edge data 0xDEADBEEF, busy 0 on both ports.
- Reserve r4 tag 1, then reserve r4 tag 2, then write-back r4 tag 1 data 0x11 -> r4 data unchanged, busy 1, tag 2, stale_count 1; then write-back r4 tag 2 data 0x22 -> data 0x22, busy 0.
- Same cycle: reserve r6 tag 9 plus write-back r6 with the old tag 7 data 0x77 (r6 previously reserved with tag 7) -> data 0x77, busy 1, tag 9.
- Reserve r1, r2, r5; assert flush together with reserve r7 -> all busy 0, r7 not reserved; then 300 write-backs to non-busy r8 -> stale_count saturates at 255.
- ZERO_REG=1: reserve r0 then write-back r0 data 0xFF -> r0 reads 0, busy 0, stale_count unchanged; assert rst mid-sequence while r3 is busy -> all outputs 0 immediately, without waiting for a clock edge.
